// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the digit width and a configuration check helper.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int BCD_W = 4;

    // True when DIGITS decimal digits can hold every WIDTH-bit value.
    function automatic bit digits_fit(input int width, input int digits);
        longint pow10;
        longint max_bin;
        pow10 = 1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 10;
        end
        max_bin = (longint'(1) << width) - 1;
        return (pow10 > max_bin);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble cell: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_W-1:0] digit_in,
    output logic [BCD_W-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_W'(5)) begin
            digit_out = digit_in + BCD_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Start/Busy/Done handshake; BCD only updates with a complete result.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [WIDTH-1:0]        Bin,
    output logic                    Busy,
    output logic                    Done,
    output logic [BCD_W*DIGITS-1:0] BCD
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SCR_W = BCD_W * DIGITS;
    localparam int SR_W  = SCR_W + WIDTH;

    generate
        if (!digits_fit(WIDTH, DIGITS)) begin : g_bad_cfg
            $error("bin2bcd_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    state_t             state_reg,   state_next;
    logic [WIDTH-1:0]   bin_reg,     bin_next;
    logic [SCR_W-1:0]   scratch_reg, scratch_next;
    logic [CNT_W-1:0]   cnt_reg,     cnt_next;
    logic [SCR_W-1:0]   bcd_reg,     bcd_next;

    logic [SCR_W-1:0]   adj_vec;
    logic [SR_W-1:0]    sr_shift;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_in  (scratch_reg[gi*BCD_W +: BCD_W]),
                .digit_out (adj_vec[gi*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // Adjust first, then shift the combined {scratch, binary} register.
    assign sr_shift = {adj_vec, bin_reg} << 1;

    always_comb begin
        state_next   = state_reg;
        bin_next     = bin_reg;
        scratch_next = scratch_reg;
        cnt_next     = cnt_reg;
        bcd_next     = bcd_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    bin_next     = Bin;
                    scratch_next = '0;
                    cnt_next     = CNT_W'(WIDTH);
                    state_next   = ST_SHIFT;
                end else begin
                    state_next   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                scratch_next = sr_shift[SR_W-1 -: SCR_W];
                bin_next     = sr_shift[WIDTH-1:0];
                cnt_next     = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    bcd_next   = sr_shift[SR_W-1 -: SCR_W];
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= ST_IDLE;
            bin_reg     <= '0;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            bcd_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            bin_reg     <= bin_next;
            scratch_reg <= scratch_next;
            cnt_reg     <= cnt_next;
            bcd_reg     <= bcd_next;
        end
    end

    assign Busy = (state_reg == ST_SHIFT);
    assign Done = (state_reg == ST_DONE);
    assign BCD  = bcd_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed plus random checks of bin2bcd_seq (8-bit/3-digit and 4-bit/2-digit)
// against a decimal reference computed with division and modulo.
module tb_bin2bcd_seq;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [7:0]  Bin;
    logic        Busy;
    logic        Done;
    logic [11:0] BCD;

    logic        Start4;
    logic [3:0]  Bin4;
    logic        Busy4;
    logic        Done4;
    logic [7:0]  BCD4;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Bin(Bin),
        .Busy(Busy), .Done(Done), .BCD(BCD)
    );

    bin2bcd_seq #(.WIDTH(4), .DIGITS(2)) u_dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start4), .Bin(Bin4),
        .Busy(Busy4), .Done(Done4), .BCD(BCD4)
    );

    // Decimal digits of v packed four bits each, units in the low nibble.
    function automatic logic [31:0] ref_bcd(input int v);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One 8-bit conversion from IDLE: accept, 8 busy cycles, one Done cycle.
    task automatic conv8(input int v);
        Bin   = 8'(v);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        Bin   = 8'($urandom);
        for (int i = 1; i <= 8; i++) begin
            chk("busy8", 32'(Busy), 32'd1);
            chk("nodone8", 32'(Done), 32'd0);
            tick();
        end
        chk("done8", 32'(Done), 32'd1);
        chk("busy8_off", 32'(Busy), 32'd0);
        chk("bcd8", 32'(BCD), ref_bcd(v) & 32'hfff);
        $display("conv8 bin=%0d bcd=%03h", v, BCD);
        tick();
        chk("done8_pulse", 32'(Done), 32'd0);
        chk("bcd8_hold", 32'(BCD), ref_bcd(v) & 32'hfff);
    endtask

    task automatic conv4(input int v);
        Bin4   = 4'(v);
        Start4 = 1'b1;
        tick();
        Start4 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("busy4", 32'(Busy4), 32'd1);
            chk("nodone4", 32'(Done4), 32'd0);
            tick();
        end
        chk("done4", 32'(Done4), 32'd1);
        chk("bcd4", 32'(BCD4), ref_bcd(v) & 32'hff);
        $display("conv4 bin=%0d bcd=%02h", v, BCD4);
        tick();
    endtask

    initial begin
        int dcnt;
        Reset  = 1'b1;
        Start  = 1'b0;
        Bin    = '0;
        Start4 = 1'b0;
        Bin4   = '0;
        tick();
        tick();
        Reset = 1'b0;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_bcd", 32'(BCD), 32'h000);
        chk("rst_bcd4", 32'(BCD4), 32'h00);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_out", {19'd0, Busy, BCD}, 32'h0);
        end

        conv8(255);
        conv8(0);
        conv8(99);
        conv8(100);
        conv8(9);
        for (int i = 0; i < 20; i++) begin
            conv8(int'($urandom_range(0, 255)));
        end

        // Start during SHIFT is ignored.
        Bin   = 8'd123;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        Bin   = 8'd45;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 4; i < 8; i++) tick();
        chk("ign_busy", 32'(Busy), 32'd1);
        tick();
        chk("ign_done", 32'(Done), 32'd1);
        chk("ign_bcd", 32'(BCD), 32'h123);
        $display("ignore-start bcd=%03h", BCD);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Done) dcnt++;
        end
        chk("ign_one_done", 32'(dcnt), 32'd0);

        // Reset aborts a conversion without Done.
        Bin   = 8'd200;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 1; i < 4; i++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_bcd", 32'(BCD), 32'h000);
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (Done) dcnt++;
            tick();
        end
        chk("abort_nodone", 32'(dcnt), 32'd0);
        $display("abort bcd=%03h", BCD);
        conv8(7);

        // Back-to-back with Start held high.
        Start = 1'b1;
        for (int j = 0; j < 3; j++) begin
            Bin = 8'(10 + j);
            tick();
            Bin = 8'($urandom);
            for (int i = 1; i < 8; i++) begin
                tick();
                chk("b2b_busy", 32'(Busy), 32'd1);
            end
            tick();
            chk("b2b_done", 32'(Done), 32'd1);
            chk("b2b_bcd", 32'(BCD), ref_bcd(10 + j) & 32'hfff);
            $display("back-to-back %0d bcd=%03h", j, BCD);
        end
        Start = 1'b0;
        tick();
        chk("b2b_idle", {30'd0, Busy, Done}, 32'd0);

        for (int v = 0; v < 16; v++) begin
            conv4(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble). Sits between a binary counter stage and the per-digit b2d_7seg decoders; it lets binary counts wider than one hex digit be shown as decimal on HEX displays. Converts one sample per request, taking one bit per clock, with a start/busy/done handshake.

Parameters:
WIDTH, 8, width of the binary input.
DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH - 1. A violating configuration is an elaboration error and is not supported.

Ports:
Clk  input  1  clock; all state changes on posedge Clk.
Reset  input  1  synchronous, active-high reset.
Start  input  1  conversion request; sampled on posedge Clk.
Bin  input  WIDTH  binary value; captured on the accepting edge only.
Busy  output  1  high while a conversion is in progress.
Done  output  1  one-cycle pulse when BCD is updated.
BCD  output  4*DIGITS  result; digit i at bits [4i+3:4i], digit 0 is units.

Behaviour:
- Reset (Reset=1 at a posedge): state=IDLE, Busy=0, Done=0, BCD=0, and all internal shift/scratch registers cleared. Reset overrides Start and aborts any in-progress conversion with no Done pulse.
- States:
  - IDLE: Busy=0, Done=0.
  - SHIFT: Busy=1, Done=0.
  - DONE: Busy=0, Done=1, held for exactly one cycle.
- Accepting a request: Start=1 at posedge k while in IDLE or DONE.
  - Bin is latched into the binary shift register.
  - The BCD scratch register is cleared and the bit counter is set to WIDTH.
  - The next state is SHIFT.
- SHIFT step, once per edge:
  - Each scratch digit >= 5 has 3 added, via the per-digit adjust unit.
  - The {scratch, binary} register is then shifted left 1, taking in the binary MSB.
  - The bit counter decrements.
- Completion: the WIDTH-th shift happens at edge k+WIDTH.
  - At that same edge, BCD is loaded with the final shifted scratch value, state goes to DONE, Done=1 and Busy=0.
  - Latency from the accepting edge to Done high is WIDTH cycles.
  - Throughput is one conversion per WIDTH+1 cycles (back-to-back Start in the DONE cycle is allowed).
- DONE with Start=0 goes to IDLE at the next edge.
- Start=1 while in SHIFT is ignored and not queued. Changes on Bin outside the accepting edge have no effect.
- BCD holds its last completed value until the next completion or Reset. It never shows partial results.
- Digit values are always 0-9. Maximum input 2^WIDTH-1 converts exactly (e.g. 255 -> 2,5,5).
- The bit counter is ceil(log2(WIDTH+1)) bits wide with no wrap-around. SHIFT exits exactly when the counter reaches 0 after a step.

Decomposition:
- Shared constants header:
  - State encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Digit width constant BCD_W=4.
- One sub-module: bcd_digit_adj. This is a combinational 4-bit "if >=5 add 3" cell, instantiated DIGITS times via generate.
- The FSM, counter and shift registers live in bin2bcd_seq.

Test Plan:
1. Reset held 2 cycles, then released -> Busy=0, Done=0, BCD=12'h000. Start=0 for 20 cycles -> outputs unchanged.
2. Bin=8'd255, Start pulsed at edge k -> Busy=1 for edges k..k+7, Done=1 only in the cycle after edge k+8, BCD=12'h255. Values 0 -> 12'h000, 99 -> 12'h099, 100 -> 12'h100, 9 -> 12'h009.
3. Start at k with Bin=8'd123, then Start=1 with Bin=8'd45 at k+3 -> second request ignored. One Done only, BCD=12'h123.
4. Start with Bin=8'd200, then Reset=1 at k+4 -> no Done, BCD=12'h000, IDLE. A new Start with Bin=8'd7 -> BCD=12'h007 after 8 cycles.
5. Back-to-back: Start held high continuously with Bin changing 10, 11, 12 at each acceptance -> Done every 9 cycles, BCD=12'h010, 12'h011, 12'h012 in order.
6. WIDTH=4, DIGITS=2: sweep Bin 0..15 -> BCD 8'h00..8'h15 decimal-correct, each with latency 4.
